// File: rtl/ec_scalar_mult.sv
// Scalar multiplier R = k*P using MSB-first double-and-add. Point additions are
// delegated to an external point-add unit; point-at-infinity cases are resolved locally.
module ec_scalar_mult #(
  parameter int W   = 6,
  parameter int K_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   in_Px,
  input  logic [W-1:0]   in_Py,
  input  logic [K_W-1:0] in_k,
  input  logic [W-1:0]   in_prime,
  input  logic [W-1:0]   in_a,
  output logic           add_valid,
  output logic [W-1:0]   add_Px,
  output logic [W-1:0]   add_Py,
  output logic [W-1:0]   add_Qx,
  output logic [W-1:0]   add_Qy,
  output logic [W-1:0]   add_prime,
  output logic [W-1:0]   add_a,
  input  logic           add_out_valid,
  input  logic [W-1:0]   add_Rx,
  input  logic [W-1:0]   add_Ry,
  output logic           out_valid,
  output logic [W-1:0]   out_Rx,
  output logic [W-1:0]   out_Ry,
  output logic           out_inf
);
  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           acc_inf_q, acc_inf_d;
  logic [W-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic [W-1:0]   px_q, px_d, py_q, py_d, prime_q, prime_d, a_q, a_d;
  logic [K_W-1:0] k_q, k_d;

  logic           add_valid_q, add_valid_d;
  logic [W-1:0]   add_px_q, add_px_d, add_py_q, add_py_d, add_qx_q, add_qx_d, add_qy_q, add_qy_d;
  logic [W-1:0]   add_prime_q, add_prime_d, add_a_q, add_a_d;
  logic           out_valid_q, out_valid_d, out_inf_q, out_inf_d;
  logic [W-1:0]   out_rx_q, out_rx_d, out_ry_q, out_ry_d;

  logic [W:0]     ysum, ysum_red;
  logic           r_is_neg_p;

  // R == -P exactly when x matches and the y coordinates cancel mod prime
  always_comb begin
    ysum       = {1'b0, ry_q} + {1'b0, py_q};
    ysum_red   = (ysum >= {1'b0, prime_q}) ? ysum - {1'b0, prime_q} : ysum;
    r_is_neg_p = (rx_q == px_q) && (ysum_red == '0);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_inf_d   = acc_inf_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    px_d        = px_q;
    py_d        = py_q;
    prime_d     = prime_q;
    a_d         = a_q;
    k_d         = k_q;
    add_valid_d = 1'b0;
    add_px_d    = '0;
    add_py_d    = '0;
    add_qx_d    = '0;
    add_qy_d    = '0;
    add_prime_d = '0;
    add_a_d     = '0;
    out_valid_d = 1'b0;
    out_rx_d    = '0;
    out_ry_d    = '0;
    out_inf_d   = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        px_d      = in_Px;
        py_d      = in_Py;
        k_d       = in_k;
        prime_d   = in_prime;
        a_d       = in_a;
        acc_inf_d = 1'b1;
        idx_d     = IW'(K_W - 1);
        state_d   = S_DBL;
      end
      S_DBL: begin
        if (acc_inf_q) begin
          state_d = S_ADD;
        end else if (ry_q == '0) begin
          acc_inf_d = 1'b1;
          state_d   = S_ADD;
        end else begin
          add_valid_d = 1'b1;
          add_px_d    = rx_q;
          add_py_d    = ry_q;
          add_qx_d    = rx_q;
          add_qy_d    = ry_q;
          add_prime_d = prime_q;
          add_a_d     = a_q;
          state_d     = S_DBL_WAIT;
        end
      end
      S_DBL_WAIT: if (add_out_valid) begin
        rx_d    = add_Rx;
        ry_d    = add_Ry;
        state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_NEXT;
        if (k_q[idx_q]) begin
          if (acc_inf_q) begin
            rx_d      = px_q;
            ry_d      = py_q;
            acc_inf_d = 1'b0;
          end else if (r_is_neg_p) begin
            acc_inf_d = 1'b1;
          end else begin
            add_valid_d = 1'b1;
            add_px_d    = rx_q;
            add_py_d    = ry_q;
            add_qx_d    = px_q;
            add_qy_d    = py_q;
            add_prime_d = prime_q;
            add_a_d     = a_q;
            state_d     = S_ADD_WAIT;
          end
        end
      end
      S_ADD_WAIT: if (add_out_valid) begin
        rx_d    = add_Rx;
        ry_d    = add_Ry;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_DBL;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        out_inf_d   = acc_inf_q;
        out_rx_d    = acc_inf_q ? '0 : rx_q;
        out_ry_d    = acc_inf_q ? '0 : ry_q;
        acc_inf_d   = 1'b1;
        idx_d       = IW'(K_W - 1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= IW'(K_W - 1);
      acc_inf_q   <= 1'b1;
      rx_q        <= '0;
      ry_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      prime_q     <= '0;
      a_q         <= '0;
      k_q         <= '0;
      add_valid_q <= 1'b0;
      add_px_q    <= '0;
      add_py_q    <= '0;
      add_qx_q    <= '0;
      add_qy_q    <= '0;
      add_prime_q <= '0;
      add_a_q     <= '0;
      out_valid_q <= 1'b0;
      out_rx_q    <= '0;
      out_ry_q    <= '0;
      out_inf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_inf_q   <= acc_inf_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      px_q        <= px_d;
      py_q        <= py_d;
      prime_q     <= prime_d;
      a_q         <= a_d;
      k_q         <= k_d;
      add_valid_q <= add_valid_d;
      add_px_q    <= add_px_d;
      add_py_q    <= add_py_d;
      add_qx_q    <= add_qx_d;
      add_qy_q    <= add_qy_d;
      add_prime_q <= add_prime_d;
      add_a_q     <= add_a_d;
      out_valid_q <= out_valid_d;
      out_rx_q    <= out_rx_d;
      out_ry_q    <= out_ry_d;
      out_inf_q   <= out_inf_d;
    end
  end

  assign add_valid = add_valid_q;
  assign add_Px    = add_px_q;
  assign add_Py    = add_py_q;
  assign add_Qx    = add_qx_q;
  assign add_Qy    = add_qy_q;
  assign add_prime = add_prime_q;
  assign add_a     = add_a_q;
  assign out_valid = out_valid_q;
  assign out_Rx    = out_rx_q;
  assign out_Ry    = out_ry_q;
  assign out_inf   = out_inf_q;
endmodule

// File: tb/tb_ec_scalar_mult.sv
// Directed bench for ec_scalar_mult on y^2 = x^3 + 2x + 2 (mod 17), P = (5,1), group order 19,
// with a behavioural point-add unit of random latency.
module tb_ec_scalar_mult;
  logic       gclk = 1'b0;
  logic       grst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_Px = '0, in_Py = '0, in_k = '0, in_prime = '0, in_a = '0;
  logic       add_valid;
  logic [5:0] add_Px, add_Py, add_Qx, add_Qy, add_prime, add_a;
  logic       add_out_valid = 1'b0;
  logic [5:0] add_Rx = '0, add_Ry = '0;
  logic       out_valid, out_inf;
  logic [5:0] out_Rx, out_Ry;

  always #5 gclk = ~gclk;

  ec_scalar_mult #(.W(6), .K_W(6)) dut (
    .clk(gclk), .rst_n(grst_n),
    .in_valid(in_valid), .in_Px(in_Px), .in_Py(in_Py), .in_k(in_k),
    .in_prime(in_prime), .in_a(in_a),
    .add_valid(add_valid), .add_Px(add_Px), .add_Py(add_Py),
    .add_Qx(add_Qx), .add_Qy(add_Qy), .add_prime(add_prime), .add_a(add_a),
    .add_out_valid(add_out_valid), .add_Rx(add_Rx), .add_Ry(add_Ry),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry), .out_inf(out_inf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int md(input int v, input int p);
    return ((v % p) + p) % p;
  endfunction

  function automatic int pw(input int b, input int e, input int p);
    int r = 1;
    for (int i = 0; i < e; i++) r = md(r * b, p);
    return r;
  endfunction

  // Behavioural point-add unit: chord or tangent, random 1..50 cycle latency
  int fixed_lat = 0;
  initial begin
    int px, py, qx, qy, p, a, l, x3, y3, lat;
    forever begin
      @(posedge gclk);
      if (add_valid === 1'b1) begin
        px = int'(add_Px); py = int'(add_Py); qx = int'(add_Qx); qy = int'(add_Qy);
        p  = int'(add_prime); a = int'(add_a);
        if (px == qx && py == qy)
          l = md(md(3 * px * px + a, p) * pw(md(2 * py, p), p - 2, p), p);
        else
          l = md(md(qy - py, p) * pw(md(qx - px, p), p - 2, p), p);
        x3  = md(l * l - px - qx, p);
        y3  = md(l * (px - x3) - py, p);
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 50));
        repeat (lat - 1) @(posedge gclk);
        #1;
        add_out_valid = 1'b1;
        add_Rx = 6'(x3);
        add_Ry = 6'(y3);
        @(posedge gclk);
        #1;
        add_out_valid = 1'b0;
        add_Rx = '0;
        add_Ry = '0;
      end
    end
  end

  // Output monitor, sampled on the falling edge
  int req_cnt = 0, out_cnt = 0, consec = 0, zero_bad = 0;
  logic prev_av = 1'b0;
  logic [5:0] f_px, f_py, f_qx, f_qy, f_pr, f_a;
  logic [5:0] r_x, r_y;
  logic r_inf;
  int first_req_at = 0;
  always @(negedge gclk) begin
    if (add_valid) begin
      if (prev_av) consec++;
      if (req_cnt == first_req_at) begin
        f_px = add_Px; f_py = add_Py; f_qx = add_Qx; f_qy = add_Qy;
        f_pr = add_prime; f_a = add_a;
      end
      req_cnt++;
    end else if ((add_Px | add_Py | add_Qx | add_Qy | add_prime | add_a) != 6'd0) begin
      zero_bad++;
    end
    if (out_valid) begin
      out_cnt++;
      r_x = out_Rx; r_y = out_Ry; r_inf = out_inf;
    end else if ((out_Rx | out_Ry) != 6'd0 || out_inf) begin
      zero_bad++;
    end
    prev_av = add_valid;
  end

  task automatic pulse_in(input logic [5:0] px, py, k, pr, a);
    @(negedge gclk);
    in_valid = 1'b1; in_Px = px; in_Py = py; in_k = k; in_prime = pr; in_a = a;
    @(negedge gclk);
    in_valid = 1'b0; in_Px = '0; in_Py = '0; in_k = '0; in_prime = '0; in_a = '0;
  endtask

  task automatic wait_out(input int base_out, input string nm);
    int n = 0;
    while (out_cnt == base_out && n < 4000) begin
      @(posedge gclk);
      n++;
    end
    if (out_cnt == base_out) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=no-result want=out_valid", nm);
    end
    repeat (5) @(posedge gclk);
  endtask

  typedef struct {
    string      nm;
    logic [5:0] px, py, k, pr, a;
    int         ex, ey, einf, ereq;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b_req, b_out;
    vecs[0] = '{"k1",   6'd5, 6'd1, 6'd1,  6'd17, 6'd2, 5,  1,  0, 0};
    vecs[1] = '{"k2",   6'd5, 6'd1, 6'd2,  6'd17, 6'd2, 6,  3,  0, 1};
    vecs[2] = '{"k3",   6'd5, 6'd1, 6'd3,  6'd17, 6'd2, 10, 6,  0, 2};
    vecs[3] = '{"k0",   6'd5, 6'd1, 6'd0,  6'd17, 6'd2, 0,  0,  1, 0};
    vecs[4] = '{"k19",  6'd5, 6'd1, 6'd19, 6'd17, 6'd2, 0,  0,  1, 5};
    vecs[5] = '{"k18",  6'd5, 6'd1, 6'd18, 6'd17, 6'd2, 5,  16, 0, 5};
    vecs[6] = '{"k5",   6'd5, 6'd1, 6'd5,  6'd17, 6'd2, 9,  16, 0, 3};
    vecs[7] = '{"k63",  6'd5, 6'd1, 6'd63, 6'd17, 6'd2, 16, 13, 0, 10};
    vecs[8] = '{"y0k2", 6'd1, 6'd0, 6'd2,  6'd17, 6'd2, 0,  0,  1, 0};

    repeat (3) @(negedge gclk);
    chk("rst_outs", int'({add_valid, out_valid, out_inf}), 0);
    chk("rst_data", int'(add_Px | add_Py | add_Qx | add_Qy | add_prime | add_a | out_Rx | out_Ry), 0);
    grst_n = 1'b1;
    repeat (2) @(negedge gclk);

    for (int i = 0; i < 9; i++) begin
      b_req = req_cnt; b_out = out_cnt;
      first_req_at = req_cnt;
      pulse_in(vecs[i].px, vecs[i].py, vecs[i].k, vecs[i].pr, vecs[i].a);
      wait_out(b_out, vecs[i].nm);
      chk({vecs[i].nm, "_nout"}, out_cnt - b_out, 1);
      chk({vecs[i].nm, "_x"},    int'(r_x), vecs[i].ex);
      chk({vecs[i].nm, "_y"},    int'(r_y), vecs[i].ey);
      chk({vecs[i].nm, "_inf"},  int'(r_inf), vecs[i].einf);
      chk({vecs[i].nm, "_nreq"}, req_cnt - b_req, vecs[i].ereq);
      if (vecs[i].ereq > 0) begin
        // the first request is always P doubled
        chk({vecs[i].nm, "_op"}, int'({f_px, f_py, f_qx, f_qy}),
            int'({vecs[i].px, vecs[i].py, vecs[i].px, vecs[i].py}));
        chk({vecs[i].nm, "_pa"}, int'({f_pr, f_a}), int'({vecs[i].pr, vecs[i].a}));
      end
    end

    // in_valid while busy must be ignored
    b_req = req_cnt; b_out = out_cnt;
    pulse_in(6'd5, 6'd1, 6'd3, 6'd17, 6'd2);
    repeat (4) @(negedge gclk);
    pulse_in(6'd5, 6'd1, 6'd2, 6'd17, 6'd2);
    wait_out(b_out, "busy");
    repeat (30) @(negedge gclk);
    chk("busy_nout", out_cnt - b_out, 1);
    chk("busy_x", int'(r_x), 10);
    chk("busy_y", int'(r_y), 6);
    chk("busy_nreq", req_cnt - b_req, 2);

    // reset while waiting on the adder during an ADD step
    fixed_lat = 50;
    b_req = req_cnt; b_out = out_cnt;
    pulse_in(6'd5, 6'd1, 6'd63, 6'd17, 6'd2);
    for (int n = 0; n < 500 && req_cnt - b_req < 2; n++) @(negedge gclk);
    chk("abort_reached", req_cnt - b_req, 2);
    repeat (3) @(negedge gclk);
    grst_n = 1'b0;
    #1;
    chk("abort_outs", int'({add_valid, out_valid, out_inf}), 0);
    chk("abort_data", int'(add_Px | add_Py | add_Qx | add_Qy | out_Rx | out_Ry), 0);
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    repeat (70) @(negedge gclk);
    chk("abort_no_out", out_cnt - b_out, 0);
    fixed_lat = 0;
    b_req = req_cnt; b_out = out_cnt;
    pulse_in(6'd5, 6'd1, 6'd3, 6'd17, 6'd2);
    wait_out(b_out, "post_rst");
    chk("post_rst_x", int'(r_x), 10);
    chk("post_rst_y", int'(r_y), 6);
    chk("post_rst_inf", int'(r_inf), 0);
    chk("post_rst_nreq", req_cnt - b_req, 2);

    chk("add_valid_back_to_back", consec, 0);
    chk("idle_outputs_zero", zero_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
